framebuffer_swap_ctrl: RTL and testbench
========================================

// Module: framebuffer_swap_ctrl
// PURPOSE
// Double-buffered framebuffer controller, generalising the fixed framebuffer configs to any geometry plus read upscaling.
// Renderer streams pixels in raster order into the back buffer.
// Display scan-out reads the front buffer, upscaled by 2**SCALE_LOG2 via pixel/line replication.
// Swaps buffers only at display frame start, so no tearing. Sits between renderer, external dual-port BRAM and VGA timing.
// PARAMETERS
// WIDTH       160  source frame width in pixels
// HEIGHT      120  source frame height in lines
// DATA_WIDTH  12   pixel width (RGB444)
// ADDR_WIDTH  $clog2(WIDTH*HEIGHT)  per-bank address width
// SCALE_LOG2  2    read upscale exponent; 0..2 legal (1x,2x,4x); display = (WIDTH<<S)x(HEIGHT<<S)
// PORTS
// clk            in   1             system clock; the block's only clock
// rst            in   1             reset, synchronous and active-high
// wr_valid       in   1             renderer pixel valid
// wr_ready       out  1             controller accepts pixel (handshake = valid&&ready)
// wr_data        in   DATA_WIDTH    pixel value
// wr_last        in   1             marks final pixel of a frame
// rd_frame_start in   1             1-cycle pulse from display timing before first visible pixel
// rd_req         in   1             display requests the next visible pixel
// rd_data        out  DATA_WIDTH    pixel returned for rd_req
// rd_valid       out  1             rd_data valid
// mem_we         out  1             BRAM write enable
// mem_waddr      out  ADDR_WIDTH+1  {bank, addr} write address
// mem_wdata      out  DATA_WIDTH    BRAM write data
// mem_raddr      out  ADDR_WIDTH+1  {bank, addr} read address
// mem_rdata      in   DATA_WIDTH    BRAM read data, 1-cycle registered read
// front_sel      out  1             bank currently displayed
// swap_pulse     out  1             1-cycle pulse on the cycle a swap takes effect
// frame_err      out  1             sticky: wr_last misaligned with WIDTH*HEIGHT pixel count
// BEHAVIOUR
// Reset (rst=1 at clk edge): front_sel=0, back bank=1, frame_ready=0, wr_addr=0, rd counters=0.
// Reset values: all outputs 0, including wr_ready; wr_ready=1 from first cycle after rst deasserts.
// Reset mid-operation discards any partial frame and in-flight read; no memory write on the reset cycle.
// Write path, accept = wr_valid&&wr_ready:
//  - mem_we=accept; mem_waddr={~front_sel, wr_addr}; mem_wdata=wr_data (combinational).
//  - wr_addr increments on accept.
//  - accept with wr_last: wr_addr->0, frame_ready<=1.
//  - if wr_addr!=WIDTH*HEIGHT-1 at that point, frame_err<=1.
//  - accept at wr_addr=WIDTH*HEIGHT-1 without wr_last: wr_addr->0, frame_err<=1, frame_ready unchanged.
//  - wr_ready = !frame_ready && !rst. Completed back buffer is frozen until swapped.
// Swap:
//  - rd_frame_start && frame_ready (registered value): front_sel toggles, frame_ready<=0, swap_pulse=1 next cycle.
//  - Frame completing in the same cycle as rd_frame_start does not swap; it waits for the next frame start.
//  - rd_frame_start with frame_ready=0: front buffer is re-displayed (frame repeat), no pulse.
// Read path, upscale:
//  - rd_frame_start: col=0, subcol=0, row_base=0, subrow=0.
//  - mem_raddr={front_sel after any swap, row_base+col} (combinational).
//  - Each rd_req: subcol++; subcol wraps at 2**S -> col++.
//  - col wraps at WIDTH = end of display line -> subrow++.
//  - subrow wraps at 2**S -> row_base+=WIDTH, otherwise row_base is replayed.
//  - row_base past last line wraps to 0 (overscan reads line 0).
//  - rd_valid/rd_data = rd_req/mem_rdata delayed by exactly 1 cycle; rd_data=0 when rd_valid=0.
//  - rd_frame_start and rd_req in the same cycle: reset counters first, then serve address 0.
//  - Address arithmetic: row_base+col < WIDTH*HEIGHT always holds; no multiplier.
// STRUCTURE
// Package buffer_config_pkg gains:
//  - scale_log2 field in buffer_config_t.
//  - function disp_width(cfg) / disp_height(cfg).
//  - configs BUFFER_160x120x12_X4 and BUFFER_320x240x12_X2 (both 640x480 display).
// Sub-module fb_scan_addr_gen holds col/subcol/row_base/subrow counters and mem_raddr generation.
// Top holds write path, swap FSM (IDLE_WRITE, FRAME_READY) and read data register.
// TESTING
// Use WIDTH=4, HEIGHT=3, SCALE_LOG2=1 unless stated.
// 1. Reset -> all outputs 0; wr_ready=1 the cycle after rst falls; front_sel=0.
// 2. Write 12 pixels 0x001..0x00C, wr_last on 12th:
//    -> mem_waddr 0x10..0x1B; wr_ready=0 after; rd_frame_start -> swap_pulse, front_sel=1, wr_ready=1.
// 3. Full scan-out, 8x6 rd_req after swap:
//    -> mem_raddr low bits 0,0,1,1,2,2,3,3 repeated twice per row, rows base 0,4,8; rd_valid 1 cycle after each rd_req.
// 4. wr_last at 5th pixel -> frame_err=1 and stays 1; wr_addr restarts at 0; rd_frame_start still swaps.
// 5. wr_last accepted same cycle as rd_frame_start -> no swap; swap_pulse occurs on the next rd_frame_start.
// 6. rst asserted mid-write (wr_addr=7) and mid-scan -> next cycle wr_addr=0, front_sel=0, rd_valid=0, no mem_we.
//    Repeat 2 & 3 with SCALE_LOG2=0 and 2 -> 1:1 and 4x replication.

Source files
------------

// File: rtl/buffer_config_pkg.sv
// Shared framebuffer geometry descriptors and the swap controller state encoding.
// Configs pair a source resolution with a read upscale so the display raster is explicit.
package buffer_config_pkg;

    typedef struct packed {
        int unsigned width;
        int unsigned height;
        int unsigned data_width;
        int unsigned scale_log2;
    } buffer_config_t;

    // Both configs scan out as a 640x480 display raster.
    localparam buffer_config_t BUFFER_160x120x12_X4 = '{
        width: 160, height: 120, data_width: 12, scale_log2: 2
    };
    localparam buffer_config_t BUFFER_320x240x12_X2 = '{
        width: 320, height: 240, data_width: 12, scale_log2: 1
    };

    typedef enum logic {
        IDLE_WRITE,
        FRAME_READY
    } swap_state_t;

    function automatic int unsigned disp_width(input buffer_config_t cfg);
        return cfg.width << cfg.scale_log2;
    endfunction

    function automatic int unsigned disp_height(input buffer_config_t cfg);
        return cfg.height << cfg.scale_log2;
    endfunction

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Scan-out address generator: walks the front buffer in raster order, replicating each
// pixel and each line 2**SCALE_LOG2 times using only adders and wrap compares.
module fb_scan_addr_gen
    import buffer_config_pkg::*;
#(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned ADDR_WIDTH = $clog2(WIDTH * HEIGHT),
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_start,
    input  logic                  i_req,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SUB_W  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_LAST = ADDR_WIDTH'(PIXELS - WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIDTH);

    logic [COL_W-1:0]      r_col,      w_col_cur,      w_col_next;
    logic [SUB_W-1:0]      r_subcol,   w_subcol_cur,   w_subcol_next;
    logic [SUB_W-1:0]      r_subrow,   w_subrow_cur,   w_subrow_next;
    logic [ADDR_WIDTH-1:0] r_row_base, w_row_base_cur, w_row_base_next;

    // Frame start clears the counters before this cycle's request is served.
    always_comb begin
        w_col_cur       = i_frame_start ? '0 : r_col;
        w_subcol_cur    = i_frame_start ? '0 : r_subcol;
        w_subrow_cur    = i_frame_start ? '0 : r_subrow;
        w_row_base_cur  = i_frame_start ? '0 : r_row_base;

        w_col_next      = w_col_cur;
        w_subcol_next   = w_subcol_cur;
        w_subrow_next   = w_subrow_cur;
        w_row_base_next = w_row_base_cur;

        if (i_req) begin
            if (w_subcol_cur == SUB_LAST) begin
                w_subcol_next = '0;
                if (w_col_cur == COL_LAST) begin
                    w_col_next = '0;
                    if (w_subrow_cur == SUB_LAST) begin
                        w_subrow_next   = '0;
                        w_row_base_next = (w_row_base_cur == BASE_LAST) ? '0
                                                                        : w_row_base_cur + ROW_STEP;
                    end else begin
                        w_subrow_next = w_subrow_cur + 1'b1;
                    end
                end else begin
                    w_col_next = w_col_cur + 1'b1;
                end
            end else begin
                w_subcol_next = w_subcol_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_subcol   <= '0;
            r_subrow   <= '0;
            r_row_base <= '0;
        end else begin
            r_col      <= w_col_next;
            r_subcol   <= w_subcol_next;
            r_subrow   <= w_subrow_next;
            r_row_base <= w_row_base_next;
        end
    end

    assign o_addr = w_row_base_cur + ADDR_WIDTH'(w_col_cur);

endmodule

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffered framebuffer controller: renderer fills the back bank, display scans the
// front bank with pixel/line replication, and banks swap only at display frame start.
module framebuffer_swap_ctrl
    import buffer_config_pkg::*;
#(
    parameter int unsigned WIDTH      = BUFFER_160x120x12_X4.width,
    parameter int unsigned HEIGHT     = BUFFER_160x120x12_X4.height,
    parameter int unsigned DATA_WIDTH = BUFFER_160x120x12_X4.data_width,
    parameter int unsigned ADDR_WIDTH = $clog2(WIDTH * HEIGHT),
    parameter int unsigned SCALE_LOG2 = BUFFER_160x120x12_X4.scale_log2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  rd_frame_start,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  front_sel,
    output logic                  swap_pulse,
    output logic                  frame_err
);

    localparam int unsigned           PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);

    swap_state_t           r_state, w_state_next;
    logic                  r_front_sel;
    logic                  r_swap_pulse;
    logic                  r_frame_err;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_rd_vld_p1;

    logic                  w_frame_ready;
    logic                  w_accept;
    logic                  w_swap;
    logic                  w_rd_bank;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // A completed back buffer is frozen until the display takes it.
    assign w_frame_ready = (r_state == FRAME_READY);
    assign wr_ready      = !w_frame_ready && !rst;
    assign w_accept      = wr_valid && wr_ready;
    assign w_swap        = rd_frame_start && w_frame_ready && !rst;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE_WRITE:  if (w_accept && wr_last) w_state_next = FRAME_READY;
            FRAME_READY: if (w_swap)              w_state_next = IDLE_WRITE;
            default:                              w_state_next = IDLE_WRITE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE_WRITE;
        else     r_state <= w_state_next;
    end

    // Write path: wr_last and the pixel count must agree, otherwise flag it and realign.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else if (w_accept) begin
            if (wr_last || (r_wr_addr == LAST_ADDR)) r_wr_addr <= '0;
            else                                     r_wr_addr <= r_wr_addr + 1'b1;
            if (wr_last ^ (r_wr_addr == LAST_ADDR))  r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_front_sel  <= 1'b0;
            r_swap_pulse <= 1'b0;
        end else begin
            r_swap_pulse <= w_swap;
            if (w_swap) r_front_sel <= ~r_front_sel;
        end
    end

    assign mem_we    = w_accept;
    assign mem_waddr = w_accept ? {~r_front_sel, r_wr_addr} : '0;
    assign mem_wdata = w_accept ? wr_data : '0;

    fb_scan_addr_gen #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_scan (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (rd_frame_start),
        .i_req         (rd_req),
        .o_addr        (w_rd_addr)
    );

    // A request coinciding with a swap already reads the newly displayed bank.
    assign w_rd_bank = r_front_sel ^ w_swap;
    assign mem_raddr = {w_rd_bank, w_rd_addr};

    // ---- stage p1: BRAM data returns alongside the delayed request ----
    always_ff @(posedge clk) begin
        if (rst) r_rd_vld_p1 <= 1'b0;
        else     r_rd_vld_p1 <= rd_req;
    end

    assign rd_valid   = r_rd_vld_p1;
    assign rd_data    = r_rd_vld_p1 ? mem_rdata : '0;
    assign front_sel  = r_front_sel;
    assign swap_pulse = r_swap_pulse;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Bench for framebuffer_swap_ctrl: three instances (1x, 2x, 4x upscale) of a 4x3 frame
// share the write/swap stimulus; a negedge monitor checks writes and reads against queues.
module tb_framebuffer_swap_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_last;
    logic [DW-1:0] wr_data;
    logic          rd_frame_start;
    logic [2:0]    rd_req;

    logic          wr_ready   [3];
    logic [DW-1:0] rd_data    [3];
    logic          rd_valid   [3];
    logic          mem_we     [3];
    logic [AW:0]   mem_waddr  [3];
    logic [DW-1:0] mem_wdata  [3];
    logic [AW:0]   mem_raddr  [3];
    logic          front_sel  [3];
    logic          swap_pulse [3];
    logic          frame_err  [3];

    logic [AW+DW:0] q_wr    [3][$];
    logic [AW:0]    q_raddr [3][$];
    logic [DW-1:0]  q_rdata [3][$];
    logic [DW-1:0]  pix     [2][W*H];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [DW-1:0] bram [0:(2<<AW)-1];
        logic [DW-1:0] bram_q;

        always @(posedge clk) begin
            if (mem_we[g]) bram[mem_waddr[g]] <= mem_wdata[g];
            bram_q <= bram[mem_raddr[g]];
        end

        framebuffer_swap_ctrl #(
            .WIDTH      (W),
            .HEIGHT     (H),
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .SCALE_LOG2 (g)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .wr_valid       (wr_valid),
            .wr_ready       (wr_ready[g]),
            .wr_data        (wr_data),
            .wr_last        (wr_last),
            .rd_frame_start (rd_frame_start),
            .rd_req         (rd_req[g]),
            .rd_data        (rd_data[g]),
            .rd_valid       (rd_valid[g]),
            .mem_we         (mem_we[g]),
            .mem_waddr      (mem_waddr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_raddr      (mem_raddr[g]),
            .mem_rdata      (bram_q),
            .front_sel      (front_sel[g]),
            .swap_pulse     (swap_pulse[g]),
            .frame_err      (frame_err[g])
        );
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every write, read address and returned pixel is matched in order.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_we[k]) begin
                if (q_wr[k].size() == 0) check($sformatf("unexpected_write_s%0d", k), int'(mem_we[k]), 0);
                else check($sformatf("write_s%0d", k), int'({mem_waddr[k], mem_wdata[k]}),
                           int'(q_wr[k].pop_front()));
            end
            if (rd_req[k] && !rst) begin
                if (q_raddr[k].size() == 0) check($sformatf("unexpected_req_s%0d", k), q_raddr[k].size(), 1);
                else check($sformatf("raddr_s%0d", k), int'(mem_raddr[k]), int'(q_raddr[k].pop_front()));
            end
            if (rd_valid[k]) begin
                if (q_rdata[k].size() == 0) check($sformatf("unexpected_rd_valid_s%0d", k), int'(rd_valid[k]), 0);
                else check($sformatf("rd_data_s%0d", k), int'(rd_data[k]), int'(q_rdata[k].pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int bank, input int addr, input int d, input bit last, input bit fs);
        check("wr_ready_before_px", int'(wr_ready[1]), 1);
        wr_valid       = 1'b1;
        wr_data        = DW'(d);
        wr_last        = last;
        rd_frame_start = fs;
        for (int k = 0; k < 3; k++) q_wr[k].push_back({1'(bank), AW'(addr), DW'(d)});
        pix[bank][addr] = DW'(d);
        tick();
        wr_valid       = 1'b0;
        wr_last        = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic write_frame(input int bank, input int n, input int last_at, input int base);
        for (int i = 0; i < n; i++) write_px(bank, i, base + i, (i == last_at), 1'b0);
    endtask

    task automatic frame_start(input int exp_swap, input int exp_front);
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("swap_pulse_s%0d", k), int'(swap_pulse[k]), exp_swap);
            check($sformatf("front_sel_s%0d", k), int'(front_sel[k]), exp_front);
        end
        tick();
        check("swap_pulse_one_cycle", int'(swap_pulse[1]), 0);
    endtask

    // Display pixel (x,y) maps to source pixel (x>>S, y>>S); overscan wraps to the top.
    task automatic scan(input int k, input int bank, input int n, input bit fs);
        int dw, dh, j, x, y, a;
        dw = W << k;
        dh = H << k;
        for (int i = 0; i < n; i++) begin
            j = i % (dw * dh);
            x = j % dw;
            y = j / dw;
            a = (y >> k) * W + (x >> k);
            q_raddr[k].push_back({1'(bank), AW'(a)});
            q_rdata[k].push_back(pix[bank][a]);
            rd_req[k]      = 1'b1;
            rd_frame_start = fs && (i == 0);
            tick();
            rd_frame_start = 1'b0;
        end
        rd_req[k] = 1'b0;
        check($sformatf("rd_valid_tail_s%0d", k), int'(rd_valid[k]), 1);
        tick();
        check($sformatf("rd_valid_idle_s%0d", k), int'(rd_valid[k]), 0);
        check($sformatf("rd_data_idle_s%0d", k), int'(rd_data[k]), 0);
    endtask

    initial begin
        rst            = 1'b1;
        wr_valid       = 1'b0;
        wr_last        = 1'b0;
        wr_data        = '0;
        rd_frame_start = 1'b0;
        rd_req         = '0;
        repeat (3) tick();

        for (int k = 0; k < 3; k++) begin
            check("rst_wr_ready",   int'(wr_ready[k]),   0);
            check("rst_front_sel",  int'(front_sel[k]),  0);
            check("rst_swap_pulse", int'(swap_pulse[k]), 0);
            check("rst_frame_err",  int'(frame_err[k]),  0);
            check("rst_rd_valid",   int'(rd_valid[k]),   0);
            check("rst_rd_data",    int'(rd_data[k]),    0);
            check("rst_mem_we",     int'(mem_we[k]),     0);
            check("rst_mem_waddr",  int'(mem_waddr[k]),  0);
            check("rst_mem_raddr",  int'(mem_raddr[k]),  0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check("wr_ready_after_rst", int'(wr_ready[k]), 1);

        // Full frame into bank 1, then swap it to the front.
        write_frame(1, 12, 11, 12'h001);
        check("wr_ready_frozen", int'(wr_ready[1]), 0);
        for (int k = 0; k < 3; k++) check("frame_err_clean", int'(frame_err[k]), 0);
        frame_start(1, 1);
        check("wr_ready_after_swap", int'(wr_ready[1]), 1);

        // Full scan-out at 1x, 2x, 4x; then frame repeat with counters reset mid-scan.
        scan(0, 1, 12, 1'b0);
        scan(1, 1, 48, 1'b0);
        scan(2, 1, 192, 1'b0);
        frame_start(0, 1);
        scan(1, 1, 3, 1'b0);
        scan(1, 1, 48, 1'b1);

        // Short frame, then a frame that overruns without wr_last, then a clean frame.
        write_frame(0, 5, 4, 12'h101);
        for (int k = 0; k < 3; k++) check("frame_err_short", int'(frame_err[k]), 1);
        check("wr_ready_short_frozen", int'(wr_ready[1]), 0);
        frame_start(1, 0);
        write_frame(1, 12, -1, 12'h301);
        check("wr_ready_overrun", int'(wr_ready[1]), 1);
        write_frame(1, 12, 11, 12'h311);
        check("wr_ready_after_overrun_frame", int'(wr_ready[1]), 0);
        for (int k = 0; k < 3; k++) check("frame_err_sticky", int'(frame_err[k]), 1);

        // Frame completing in the same cycle as frame start must wait one frame.
        frame_start(1, 1);
        scan(0, 1, 12, 1'b0);
        write_frame(0, 11, -1, 12'h401);
        write_px(0, 11, 12'h40C, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("late_frame_no_pulse", int'(swap_pulse[k]), 0);
            check("late_frame_front",    int'(front_sel[k]),  1);
        end
        check("late_frame_wr_ready", int'(wr_ready[1]), 0);
        frame_start(1, 0);
        scan(1, 0, 48, 1'b0);

        // Reset mid-write (wr_addr=7) with front_sel=1 and a read in flight.
        write_frame(1, 12, 11, 12'h501);
        frame_start(1, 1);
        write_frame(0, 7, -1, 12'h601);
        frame_start(0, 1);
        scan(1, 1, 5, 1'b0);
        rst       = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = 12'h7FF;
        rd_req[1] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_cycle_mem_we",   int'(mem_we[k]),   0);
            check("rst_cycle_wr_ready", int'(wr_ready[k]), 0);
        end
        tick();
        wr_valid  = 1'b0;
        rd_req[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("midrst_rd_valid",  int'(rd_valid[k]),  0);
            check("midrst_front_sel", int'(front_sel[k]), 0);
            check("midrst_frame_err", int'(frame_err[k]), 0);
        end
        rst = 1'b0;
        scan(1, 0, 4, 1'b0);
        write_frame(1, 12, 11, 12'h701);
        frame_start(1, 1);
        scan(1, 1, 48, 1'b0);
        repeat (2) tick();

        for (int k = 0; k < 3; k++) begin
            check($sformatf("writes_drained_s%0d", k), q_wr[k].size(), 0);
            check($sformatf("reqs_drained_s%0d", k),   q_raddr[k].size(), 0);
            check($sformatf("reads_drained_s%0d", k),  q_rdata[k].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
